// File: rtl/nonce_scan_ctrl.sv
// Nonce scan controller: walks one sha256 core through a nonce range for a mining job,
// comparing every hash against the job target and handing winning nonces to a consumer.
module nonce_scan_ctrl #(
  parameter logic [31:0] NONCE_START    = 32'h0000_0000,
  parameter logic [31:0] NONCE_END      = 32'hFFFF_FFFF,
  parameter logic [31:0] NONCE_STEP     = 32'd1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [639:0] job_header,
  input  logic [255:0] job_target,
  input  logic         abort,
  output logic         core_start,
  output logic [639:0] core_data,
  input  logic [255:0] core_hash,
  input  logic         core_ready,
  output logic         found_valid,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
  input  logic         found_ack,
  output logic         busy,
  output logic         exhausted,
  output logic         timeout_err,
  output logic [31:0]  hashes_done,
  output logic [2:0]   dbg_state
);

  // Handshakes: a job transfers on a cycle with job_valid && job_ready; a result transfers on a
  // cycle with found_valid && found_ack; the core holds core_start until it has raised core_ready,
  // and core_start is not raised again until core_ready has returned low.

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_COMPARE = 3'd3,
    S_RELEASE = 3'd4,
    S_REPORT  = 3'd5,
    S_NEXT    = 3'd6
  } state_t;

  state_t          r_state;
  logic [31:0]     r_nonce;
  logic [255:0]    r_target;
  logic [255:0]    r_hash;
  logic            r_win;
  logic            r_abort_pend;
  logic [CW-1:0]   r_wait_cnt;
  logic            r_job_ready;
  logic            r_busy;
  logic            r_core_start;
  logic [639:0]    r_core_data;
  logic            r_found_valid;
  logic [31:0]     r_found_nonce;
  logic [255:0]    r_found_hash;
  logic            r_exhausted;
  logic            r_timeout;
  logic [31:0]     r_hashes;

  logic [31:0]     w_next_nonce;
  logic            w_last;
  logic [31:0]     w_unused_nonce_field;

  // The end test is phrased as a distance so the 32-bit add can never wrap past NONCE_END.
  assign w_next_nonce         = r_nonce + NONCE_STEP;
  assign w_last               = (r_nonce == NONCE_END) || ((NONCE_END - r_nonce) < NONCE_STEP);
  assign w_unused_nonce_field = job_header[31:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_nonce       <= NONCE_START;
      r_target      <= '0;
      r_hash        <= '0;
      r_win         <= 1'b0;
      r_abort_pend  <= 1'b0;
      r_wait_cnt    <= '0;
      r_job_ready   <= 1'b1;
      r_busy        <= 1'b0;
      r_core_start  <= 1'b0;
      r_core_data   <= '0;
      r_found_valid <= 1'b0;
      r_found_nonce <= '0;
      r_found_hash  <= '0;
      r_exhausted   <= 1'b0;
      r_timeout     <= 1'b0;
      r_hashes      <= '0;
    end else begin
      r_exhausted <= 1'b0;
      if (r_state != S_IDLE && abort) r_abort_pend <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (job_valid) begin
            r_target     <= job_target;
            r_nonce      <= NONCE_START;
            r_core_data  <= {job_header[639:32], NONCE_START};
            r_hashes     <= '0;
            r_abort_pend <= 1'b0;
            r_job_ready  <= 1'b0;
            r_busy       <= 1'b1;
            r_core_start <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wait_cnt <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (core_ready) begin
            r_hash       <= core_hash;
            r_core_start <= 1'b0;
            r_state      <= S_COMPARE;
          end else if (r_wait_cnt == TO_LAST) begin
            r_timeout    <= 1'b1;
            r_core_start <= 1'b0;
            r_job_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
        end
        S_COMPARE: begin
          r_win    <= (r_hash <= r_target);
          r_hashes <= r_hashes + 32'd1;
          r_state  <= S_RELEASE;
        end
        S_RELEASE: begin
          // Let the core fall back to idle before anything else is asked of it.
          if (!core_ready) begin
            if (r_win) begin
              r_found_valid <= 1'b1;
              r_found_nonce <= r_nonce;
              r_found_hash  <= r_hash;
              r_state       <= S_REPORT;
            end else begin
              r_state <= S_NEXT;
            end
          end
        end
        S_REPORT: begin
          if (found_ack) begin
            r_found_valid <= 1'b0;
            r_state       <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (r_abort_pend) begin
            r_abort_pend <= 1'b0;
            r_job_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end else if (w_last) begin
            r_exhausted <= 1'b1;
            r_job_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_nonce            <= w_next_nonce;
            r_core_data[31:0]  <= w_next_nonce;
            r_core_start       <= 1'b1;
            r_state            <= S_ISSUE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign job_ready   = r_job_ready;
  assign busy        = r_busy;
  assign core_start  = r_core_start;
  assign core_data   = r_core_data;
  assign found_valid = r_found_valid;
  assign found_nonce = r_found_nonce;
  assign found_hash  = r_found_hash;
  assign exhausted   = r_exhausted;
  assign timeout_err = r_timeout;
  assign hashes_done = r_hashes;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_nonce_scan_ctrl.sv
// Bench for nonce_scan_ctrl: a stub sha256 core with programmable latency, random jobs checked
// against a range/target model, plus directed abort, watchdog and mid-report reset scenarios.
module tb_nonce_scan_ctrl;

  localparam logic [31:0] P_START = 32'hFFFF_FFF0;
  localparam logic [31:0] P_END   = 32'hFFFF_FFFF;
  localparam logic [31:0] P_STEP  = 32'd4;
  localparam int          P_TO    = 255;

  logic         clk = 1'b0;
  logic         reset;
  logic         job_valid;
  logic         job_ready;
  logic [639:0] job_header;
  logic [255:0] job_target;
  logic         abort;
  logic         core_start;
  logic [639:0] core_data;
  logic [255:0] core_hash;
  logic         core_ready;
  logic         found_valid;
  logic [31:0]  found_nonce;
  logic [255:0] found_hash;
  logic         found_ack;
  logic         busy;
  logic         exhausted;
  logic         timeout_err;
  logic [31:0]  hashes_done;
  logic [2:0]   dbg_state;

  int n_vec = 0;
  int n_err = 0;

  int          stub_lat  = 68;
  int          stub_rel  = 0;
  bit          stub_hang = 1'b0;
  int          st_cnt;
  int          st_rel;
  logic [607:0] cur_hdr_hi;
  logic [31:0] iss_q[$];
  logic [31:0] exp_iss[$];
  logic [31:0] exp_q[$];
  logic        mon_prev_start;
  logic        mon_saw_ready;

  nonce_scan_ctrl #(
    .NONCE_START(P_START), .NONCE_END(P_END), .NONCE_STEP(P_STEP), .TIMEOUT_CYCLES(P_TO)
  ) u_dut (
    .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
    .job_header(job_header), .job_target(job_target), .abort(abort),
    .core_start(core_start), .core_data(core_data), .core_hash(core_hash),
    .core_ready(core_ready), .found_valid(found_valid), .found_nonce(found_nonce),
    .found_hash(found_hash), .found_ack(found_ack), .busy(busy), .exhausted(exhausted),
    .timeout_err(timeout_err), .hashes_done(hashes_done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] stub_hash(input logic [31:0] n);
    return {n ^ 32'h5A5A_5A5A, {6{n}}, n};
  endfunction

  task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stub core: result appears stub_lat cycles after start, ready lingers stub_rel cycles after start drops.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      st_cnt     <= 0;
      st_rel     <= 0;
      core_ready <= 1'b0;
      core_hash  <= '0;
    end else if (core_start) begin
      if (!stub_hang && !core_ready) begin
        if (st_cnt == stub_lat - 1) begin
          core_ready <= 1'b1;
          core_hash  <= stub_hash(core_data[31:0]);
        end else begin
          st_cnt <= st_cnt + 1;
        end
      end
    end else begin
      st_cnt <= 0;
      if (core_ready) begin
        if (st_rel >= stub_rel) begin
          core_ready <= 1'b0;
          st_rel     <= 0;
        end else begin
          st_rel <= st_rel + 1;
        end
      end
    end
  end

  // Issue monitor: records each start, checks the header field and that start was held to ready.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mon_prev_start <= 1'b0;
      mon_saw_ready  <= 1'b0;
    end else begin
      if (core_start && !mon_prev_start) begin
        iss_q.push_back(core_data[31:0]);
        check("issue_header", {32'h0, core_data[639:32]}, {32'h0, cur_hdr_hi});
        mon_saw_ready <= 1'b0;
      end
      if (core_start && core_ready) mon_saw_ready <= 1'b1;
      if (!core_start && mon_prev_start) check("start_held_to_ready", mon_saw_ready, !stub_hang);
      mon_prev_start <= core_start;
    end
  end

  task automatic model_job(input logic [255:0] tgt, input int abort_idx);
    logic [63:0] v;
    exp_iss.delete();
    exp_q.delete();
    v = {32'h0, P_START};
    while (v <= {32'h0, P_END}) begin
      if (abort_idx >= 0 && exp_iss.size() > abort_idx) break;
      exp_iss.push_back(v[31:0]);
      v = v + {32'h0, P_STEP};
    end
    foreach (exp_iss[i]) if (stub_hash(exp_iss[i]) <= tgt) exp_q.push_back(exp_iss[i]);
  endtask

  task automatic start_job(input logic [255:0] tgt, input bit abort_too);
    logic [639:0] hdr;
    for (int i = 0; i < 20; i++) hdr[i*32 +: 32] = $urandom();
    cur_hdr_hi = hdr[639:32];
    iss_q.delete();
    check("job_ready_before_accept", job_ready, 1);
    job_header = hdr;
    job_target = tgt;
    job_valid  = 1'b1;
    abort      = abort_too;
    @(negedge clk);
    job_valid = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic run_job(input logic [255:0] tgt, input int abort_idx, input bit abort_at_accept);
    int   cyc, exh, ack_dly;
    bit   done, aborted, in_rep;
    logic [31:0] cur_n;
    model_job(tgt, abort_idx);
    start_job(tgt, abort_at_accept);
    cyc = 0; exh = 0; ack_dly = 0; done = 0; aborted = 0; in_rep = 0; cur_n = '0;
    while (!done && cyc < 3000) begin
      found_ack = 1'b0; abort = 1'b0; job_valid = 1'b0;
      if (exhausted) exh++;
      if (found_valid) begin
        if (!in_rep) begin
          in_rep  = 1;
          ack_dly = $urandom_range(0, 3);
          if (exp_q.size() == 0) begin
            check("unexpected_win", 1, 0);
            cur_n = found_nonce;
          end else begin
            cur_n = exp_q.pop_front();
          end
        end
        check("found_nonce", found_nonce, cur_n);
        check("found_hash", found_hash, stub_hash(cur_n));
        if (ack_dly == 0) found_ack = 1'b1;
        else ack_dly--;
      end else begin
        in_rep = 0;
        if ($urandom_range(0, 7) == 0) found_ack = 1'b1;
      end
      if (busy && $urandom_range(0, 15) == 0) begin
        job_valid  = 1'b1;
        job_header = ~job_header;
      end
      if (abort_idx >= 0 && !aborted && iss_q.size() == abort_idx + 1 && core_start && !core_ready) begin
        abort   = 1'b1;
        aborted = 1;
      end
      if (job_ready) done = 1;
      @(negedge clk);
      cyc++;
    end
    found_ack = 1'b0; abort = 1'b0; job_valid = 1'b0;
    repeat (2) begin
      if (exhausted) exh++;
      @(negedge clk);
    end
    check("job_done_in_budget", done, 1);
    check("issued_count", iss_q.size(), exp_iss.size());
    for (int i = 0; i < exp_iss.size() && i < iss_q.size(); i++) check("issued_nonce", iss_q[i], exp_iss[i]);
    check("wins_unreported", exp_q.size(), 0);
    check("exhausted_pulses", exh, (abort_idx < 0) ? 1 : 0);
    check("hashes_done", hashes_done, exp_iss.size());
    check("idle_busy_start_found", {busy, core_start, found_valid}, 0);
  endtask

  initial begin
    int c;
    int sel;
    logic [255:0] tgt;
    reset = 1'b1; job_valid = 1'b0; job_header = '0; job_target = '0; abort = 1'b0; found_ack = 1'b0;
    cur_hdr_hi = '0;
    repeat (3) @(negedge clk);
    check("rst_job_ready", job_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_core_start", core_start, 0);
    check("rst_core_data", core_data, 0);
    check("rst_found", {found_valid, found_nonce, found_hash}, 0);
    check("rst_flags", {exhausted, timeout_err}, 0);
    check("rst_hashes_done", hashes_done, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed jobs at the reference 68-cycle core latency.
    run_job('0, -1, 0);
    run_job(stub_hash(P_START + P_STEP), -1, 0);
    run_job('1, -1, 1);
    run_job(stub_hash(P_START + 2 * P_STEP) - 256'd1, 2, 0);
    run_job('1, 3, 0);

    for (int j = 0; j < 10; j++) begin
      stub_lat = $urandom_range(2, 80);
      stub_rel = $urandom_range(0, 3);
      sel = $urandom_range(0, 4);
      case (sel)
        0: tgt = '0;
        1: tgt = '1;
        2: tgt = stub_hash(P_START + P_STEP * $urandom_range(0, 3));
        3: tgt = stub_hash(P_START + P_STEP * $urandom_range(0, 3)) - 256'd1;
        default: tgt = {$urandom(), $urandom(), $urandom(), $urandom(),
                        $urandom(), $urandom(), $urandom(), $urandom()};
      endcase
      run_job(tgt, int'($urandom_range(0, 4)) - 1, 1'($urandom_range(0, 1)));
    end

    // Watchdog: a core that never answers.
    stub_hang = 1'b1;
    start_job('1, 0);
    check("to_start_raised", core_start, 1);
    c = 0;
    while (!timeout_err && c < 400) begin
      @(negedge clk);
      c++;
    end
    check("timeout_latency", c, 1 + P_TO);
    check("to_core_start", core_start, 0);
    check("to_job_ready", job_ready, 1);
    check("to_busy", busy, 0);
    check("to_hashes_done", hashes_done, 0);
    repeat (3) @(negedge clk);
    stub_hang = 1'b0;
    stub_lat  = 20;
    run_job('0, -1, 0);
    check("timeout_sticky", timeout_err, 1);

    // Asynchronous reset while a win is waiting for its ack.
    stub_lat = 10;
    start_job('1, 0);
    c = 0;
    while (!found_valid && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("report_reached", found_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_found_valid", found_valid, 0);
    check("arst_core_start", core_start, 0);
    check("arst_job_ready", job_ready, 1);
    check("arst_busy", busy, 0);
    check("arst_timeout_err", timeout_err, 0);
    check("arst_hashes_done", hashes_done, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    stub_lat = 68;
    run_job(stub_hash(P_START), -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
